// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop deframer
// feeding a 2-entry output FIFO with error and overrun pulses.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic                perr_q;
  logic                ferr_q;
  logic                ovr_q;

  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic [1:0]          occ_q, occ_d;
  logic                valid_q;

  logic                par_bad;
  logic                wr;
  logic                pop;
  logic                full;

  assign par_bad = (PARITY_EN != 0) && par_q;
  assign wr      = (state_q == STOP) && !sdi && !par_bad;
  assign pop     = valid_q && dout_ready;
  assign full    = (occ_q == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sdi) begin
            state_q <= DATA;
            cnt_q   <= '0;
            par_q   <= 1'b0;
          end
        end
        DATA: begin
          shift_q[cnt_q] <= sdi;
          par_q          <= par_q ^ sdi;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q   <= '0;
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_q   <= par_q ^ sdi;
          state_q <= STOP;
        end
        STOP: begin
          // Back to IDLE unconditionally: a 1 here is a bad stop,
          // never a new start bit.
          state_q <= IDLE;
          if (sdi) begin
            ferr_q <= 1'b1;
          end else if (par_bad) begin
            perr_q <= 1'b1;
          end else if (full && !pop) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (wr) begin
          head_d = shift_q;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (wr && pop) begin
          head_d = shift_q;
        end else if (wr) begin
          tail_d = shift_q;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: a write is only taken when a pop frees the slot.
        if (pop) begin
          head_d = tail_q;
          if (wr) begin
            tail_d = shift_q;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign dout       = head_q;
  assign dout_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, even parity):
// table of single frames plus hand sequences for FIFO and reset cases.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset_n;
  logic       sdi;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  serial_frame_rx #(
    .DATA_W    (8),
    .PARITY_EN (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sdi        (sdi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         pflip;
    bit         stop;
    bit         e_valid;
    logic [7:0] e_dout;
    bit         e_perr;
    bit         e_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one frame on the negedges; returns #1 after the stop edge.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input logic rdy_stop);
    @(negedge clk);
    sdi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sdi = d[i];
    end
    @(negedge clk);
    sdi = p;
    @(negedge clk);
    sdi = s;
    if (rdy_stop) dout_ready = 1'b1;
    @(posedge clk);
    #1;
    sdi = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

    reset_n    = 1'b0;
    sdi        = 1'b1;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, dout_valid}, 32'd0);
    chk("rst_dout", {24'b0, dout}, 32'd0);
    chk("rst_perr", {31'b0, parity_err}, 32'd0);
    chk("rst_ferr", {31'b0, frame_err}, 32'd0);
    chk("rst_ovr", {31'b0, overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sdi     = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames, consumer always ready
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k].d, (^vecs[k].d) ^ vecs[k].pflip,
                 vecs[k].stop, 1'b0);
      chk($sformatf("v%0d_valid", k), {31'b0, dout_valid},
          {31'b0, vecs[k].e_valid});
      if (vecs[k].e_valid)
        chk($sformatf("v%0d_dout", k), {24'b0, dout},
            {24'b0, vecs[k].e_dout});
      chk($sformatf("v%0d_perr", k), {31'b0, parity_err},
          {31'b0, vecs[k].e_perr});
      chk($sformatf("v%0d_ferr", k), {31'b0, frame_err},
          {31'b0, vecs[k].e_ferr});
      chk($sformatf("v%0d_ovr", k), {31'b0, overrun}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_perr_end", k), {31'b0, parity_err}, 32'd0);
      chk($sformatf("v%0d_ferr_end", k), {31'b0, frame_err}, 32'd0);
      chk($sformatf("v%0d_valid_end", k), {31'b0, dout_valid}, 32'd0);
    end

    // Bad stop bit followed immediately by a new frame
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0);
    chk("b2b_ferr", {31'b0, frame_err}, 32'd1);
    send_frame(8'h5A, ^8'h5A, 1'b0, 1'b0);
    chk("b2b_valid", {31'b0, dout_valid}, 32'd1);
    chk("b2b_dout", {24'b0, dout}, 32'h5A);
    chk("b2b_ferr_end", {31'b0, frame_err}, 32'd0);
    @(posedge clk);
    #1;

    // Overrun with consumer stalled
    dout_ready = 1'b0;
    send_frame(8'h01, ^8'h01, 1'b0, 1'b0);
    chk("ov1_valid", {31'b0, dout_valid}, 32'd1);
    chk("ov1_dout", {24'b0, dout}, 32'h01);
    send_frame(8'h02, ^8'h02, 1'b0, 1'b0);
    chk("ov2_dout", {24'b0, dout}, 32'h01);
    chk("ov2_ovr", {31'b0, overrun}, 32'd0);
    send_frame(8'h03, ^8'h03, 1'b0, 1'b0);
    chk("ov3_ovr", {31'b0, overrun}, 32'd1);
    chk("ov3_dout", {24'b0, dout}, 32'h01);
    chk("ov3_valid", {31'b0, dout_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ov3_ovr_end", {31'b0, overrun}, 32'd0);
    chk("ov3_hold", {24'b0, dout}, 32'h01);
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ov_pop1", {24'b0, dout}, 32'h02);
    chk("ov_pop1_v", {31'b0, dout_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ov_pop2_v", {31'b0, dout_valid}, 32'd0);

    // Full buffer, write coincides with a pop
    dout_ready = 1'b0;
    send_frame(8'h01, ^8'h01, 1'b0, 1'b0);
    send_frame(8'h02, ^8'h02, 1'b0, 1'b0);
    send_frame(8'h03, ^8'h03, 1'b0, 1'b1);
    chk("fp_ovr", {31'b0, overrun}, 32'd0);
    chk("fp_valid", {31'b0, dout_valid}, 32'd1);
    chk("fp_dout", {24'b0, dout}, 32'h02);
    @(posedge clk);
    #1;
    chk("fp_pop1", {24'b0, dout}, 32'h03);
    chk("fp_pop1_v", {31'b0, dout_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("fp_pop2_v", {31'b0, dout_valid}, 32'd0);

    // Reset in the middle of a frame with a word buffered
    dout_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b0, 1'b0);
    chk("mr_pre_v", {31'b0, dout_valid}, 32'd1);
    @(negedge clk);
    sdi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sdi = i[0];
    end
    @(negedge clk);
    reset_n = 1'b0;
    sdi     = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_valid", {31'b0, dout_valid}, 32'd0);
    chk("mr_dout", {24'b0, dout}, 32'd0);
    chk("mr_perr", {31'b0, parity_err}, 32'd0);
    chk("mr_ferr", {31'b0, frame_err}, 32'd0);
    chk("mr_ovr", {31'b0, overrun}, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    sdi        = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h5A, ^8'h5A, 1'b0, 1'b0);
    chk("mr_post_v", {31'b0, dout_valid}, 32'd1);
    chk("mr_post_dout", {24'b0, dout}, 32'h5A);
    chk("mr_post_perr", {31'b0, parity_err}, 32'd0);
    chk("mr_post_ferr", {31'b0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 = even-parity bit present in the frame, 0 = no parity bit.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sdi  input  1  serial line from the upstream shift-register sdo; one bit sampled per clk edge; line idles low.
REQ-006 SHALL have port dout  output  DATA_W  received word at the head of the output buffer.
REQ-007 SHALL have port dout_valid  output  1  output buffer non-empty; dout is valid.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout on an edge where dout_valid && dout_ready.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse: frame discarded, parity mismatch.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame discarded, stop bit was 1.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped, buffer full.

Function
REQ-012 Frame format SHALL be: start bit 1; DATA_W data bits, LSB first; parity bit if PARITY_EN; stop bit 0.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP; one sdi sample per state-cycle.
REQ-014 IDLE: sdi==1 sampled -> DATA with bit counter = 0; sdi==0 -> stay IDLE.
REQ-015 DATA: shift sdi into bit position = counter; after the sample at counter==DATA_W-1 -> PARITY if PARITY_EN, else STOP.
REQ-016 PARITY: capture sdi as the received parity bit -> STOP; parity is good when XOR(data bits, parity bit) == 0.
REQ-017 STOP: always -> IDLE; a 1 sampled in STOP SHALL NOT be treated as a new start bit.
REQ-018 At the STOP-sample edge, precedence SHALL be: stop==1 -> frame_err; else parity bad -> parity_err; else buffer write (or overrun if full).
REQ-019 Frame_err and parity_err SHALL be exclusive; a discarded frame SHALL NOT touch the buffer.
REQ-020 Output buffer SHALL be a 2-entry FIFO; dout SHALL show the oldest entry.
REQ-021 A written word SHALL make dout_valid 1 in the cycle after the STOP-sample edge; latency from start-bit edge = DATA_W+2 edges (PARITY_EN=1) or DATA_W+1 edges (PARITY_EN=0).
REQ-022 Pop and write on the same edge when full SHALL accept the write; occupancy stays 2 and no overrun is raised.
REQ-023 Write when full with no pop SHALL drop the new word, keep the buffer unchanged, and pulse overrun.
REQ-024 dout SHALL remain stable while dout_valid && !dout_ready.
REQ-025 Error/overrun pulses SHALL be registered, high for exactly the one cycle after the STOP-sample edge.

Reset
REQ-026 reset_n==0 at an edge SHALL force: FSM IDLE, counter 0, buffer empty, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release the block waits for a new start bit in IDLE.
REQ-028 Reset SHALL take priority over all other events on the same edge.

Verification
REQ-029 DATA_W=8, PARITY_EN=1; sdi = 1, 1,0,1,0,0,1,0,1, 0, 0 (0xA5, parity 0, stop 0), dout_ready=1 -> dout=0xA5, dout_valid high 1 cycle after edge 10; no error pulses.
REQ-030 Same frame with parity bit 1 -> parity_err pulses one cycle; dout_valid stays 0.
REQ-031 Frame 0x3C with stop bit 1 -> frame_err pulses; next edge in IDLE with sdi=1 starts a new frame only after the STOP cycle.
REQ-032 dout_ready=0; send 0x01, 0x02, 0x03 back-to-back -> dout=0x01, dout_valid=1, overrun pulses on the third frame; then ready=1 -> 0x01 then 0x02 popped, 0x03 never appears.
REQ-033 Buffer full; third frame completes on an edge where dout_ready=1 -> no overrun; dout sequence 0x02, 0x03.
REQ-034 reset_n=0 after the 4th data bit of a frame, for one edge -> all outputs 0; the next complete frame 0x5A is received correctly.
